flow_match_table: RTL and testbench

- Match stage directly downstream of the flow-key generator.
- Consumes each 128-bit 5-tuple flow key and its one-cycle valid strobe, and compares it against a register-based, fully associative table of DEPTH programmed entries.
- Emits hit/miss, matched index and action ID with fixed 2-cycle latency.
- Keeps per-entry saturating hit counters and a miss counter, readable by the PS-side control path.

---
 rtl/flow_match_table_if.sv | 40 ++++
 rtl/flow_match_table.sv | 144 ++++++++++++++
 tb/tb_flow_match_table.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_match_table_if.sv
// Lookup, table-programming and statistics signals of flow_match_table.
// master = driver side (key source / control path), slave = match table.
interface flow_match_table_if #(
  parameter int DEPTH    = 16,
  parameter int ACTION_W = 8,
  parameter int CNT_W    = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [127:0]         flow_key;
  logic                 valid_flow_key;
  logic                 cfg_wr_en;
  logic [IDX_W-1:0]     cfg_idx;
  logic                 cfg_entry_valid;
  logic [127:0]         cfg_key;
  logic [ACTION_W-1:0]  cfg_action;
  logic                 stat_rd_en;
  logic [IDX_W-1:0]     stat_idx;
  logic [CNT_W-1:0]     stat_hit_cnt;
  logic                 stat_rd_valid;
  logic [CNT_W-1:0]     miss_cnt;
  logic                 match_valid;
  logic                 match_hit;
  logic [IDX_W-1:0]     match_idx;
  logic [ACTION_W-1:0]  match_action;

  modport master (
    output flow_key, valid_flow_key, cfg_wr_en, cfg_idx, cfg_entry_valid,
           cfg_key, cfg_action, stat_rd_en, stat_idx,
    input  stat_hit_cnt, stat_rd_valid, miss_cnt, match_valid, match_hit,
           match_idx, match_action
  );

  modport slave (
    input  flow_key, valid_flow_key, cfg_wr_en, cfg_idx, cfg_entry_valid,
           cfg_key, cfg_action, stat_rd_en, stat_idx,
    output stat_hit_cnt, stat_rd_valid, miss_cnt, match_valid, match_hit,
           match_idx, match_action
  );
endinterface

// File: rtl/flow_match_table.sv
// Fully associative flow-key match table with fixed 2-cycle lookup latency,
// lowest-index-wins priority, per-entry saturating hit counters and a
// saturating miss counter. A lookup is resolved against the table contents
// as they stand in the strobe cycle, so a same-cycle table write is not seen
// by that lookup but is seen by every later one.
module flow_match_table #(
  parameter int                  DEPTH          = 16,
  parameter int                  ACTION_W       = 8,
  parameter int                  CNT_W          = 32,
  parameter logic [ACTION_W-1:0] DEFAULT_ACTION = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  flow_match_table_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]    entry_vld;
  logic [103:0]        entry_key    [DEPTH];
  logic [ACTION_W-1:0] entry_action [DEPTH];
  logic [CNT_W-1:0]    hit_cnt      [DEPTH];
  logic [CNT_W-1:0]    miss_cnt_r;

  logic [DEPTH-1:0]    cmp_vec;
  logic                enc_hit;
  logic [IDX_W-1:0]    enc_idx;
  logic [ACTION_W-1:0] enc_action;

  logic                vld_p1, hit_p1;
  logic [IDX_W-1:0]    idx_p1;
  logic [ACTION_W-1:0] action_p1;
  logic                vld_p2, hit_p2;
  logic [IDX_W-1:0]    idx_p2;
  logic [ACTION_W-1:0] action_p2;

  logic                stat_vld_r;
  logic [CNT_W-1:0]    stat_cnt_r;

  // Upper 24 key bits are padding and take no part in matching.
  logic unused_key_hi;
  assign unused_key_hi = ^{bus.flow_key[127:104], bus.cfg_key[127:104]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage 0: compare the incoming key against every valid entry.
  always_comb begin
    cmp_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      cmp_vec[i] = entry_vld[i] && (entry_key[i] == bus.flow_key[103:0]);
  end

  // Priority encode the compare vector; the lowest matching index wins.
  always_comb begin
    enc_hit    = 1'b0;
    enc_idx    = '0;
    enc_action = DEFAULT_ACTION;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cmp_vec[i]) begin
        enc_hit    = 1'b1;
        enc_idx    = IDX_W'(i);
        enc_action = entry_action[i];
      end
    end
  end

  // Stage 1: register the resolved lookup; only the valid bit is reset.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= bus.valid_flow_key;
    hit_p1    <= enc_hit;
    idx_p1    <= enc_idx;
    action_p1 <= enc_action;
  end

  // Stage 2: result outputs, pulsed valid and held fields between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      hit_p2    <= 1'b0;
      idx_p2    <= '0;
      action_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        hit_p2    <= hit_p1;
        idx_p2    <= idx_p1;
        action_p2 <= action_p1;
      end
    end
  end

  // Table programming from the control path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_key[i]    <= '0;
        entry_action[i] <= '0;
      end
    end else if (bus.cfg_wr_en) begin
      entry_vld[bus.cfg_idx]    <= bus.cfg_entry_valid;
      entry_key[bus.cfg_idx]    <= bus.cfg_key[103:0];
      entry_action[bus.cfg_idx] <= bus.cfg_action;
    end
  end

  // Hit/miss counters advance on the result cycle; a table write clears the
  // entry's counter and takes precedence over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_cnt_r <= '0;
      for (int i = 0; i < DEPTH; i++) hit_cnt[i] <= '0;
    end else begin
      if (vld_p2 && !hit_p2) miss_cnt_r <= sat_inc(miss_cnt_r);
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cfg_wr_en && (bus.cfg_idx == IDX_W'(i)))
          hit_cnt[i] <= '0;
        else if (vld_p2 && hit_p2 && (idx_p2 == IDX_W'(i)))
          hit_cnt[i] <= sat_inc(hit_cnt[i]);
      end
    end
  end

  // Counter read port: one-cycle latency, data holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_vld_r <= 1'b0;
      stat_cnt_r <= '0;
    end else begin
      stat_vld_r <= bus.stat_rd_en;
      if (bus.stat_rd_en) stat_cnt_r <= hit_cnt[bus.stat_idx];
    end
  end

  assign bus.match_valid   = vld_p2;
  assign bus.match_hit     = hit_p2;
  assign bus.match_idx     = idx_p2;
  assign bus.match_action  = action_p2;
  assign bus.miss_cnt      = miss_cnt_r;
  assign bus.stat_rd_valid = stat_vld_r;
  assign bus.stat_hit_cnt  = stat_cnt_r;
endmodule

// File: tb/tb_flow_match_table.sv
// Self-checking bench for flow_match_table: a queue-based reference model of
// the table, scenario checks with literal expectations, randomized traffic,
// and a narrow-counter instance for saturation.
module tb_flow_match_table;
  localparam int         DEPTH   = 16;
  localparam logic [7:0] DEF_ACT = 8'hEE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flow_match_table_if #(.DEPTH(16), .ACTION_W(8), .CNT_W(32)) bus ();
  flow_match_table_if #(.DEPTH(4),  .ACTION_W(4), .CNT_W(4))  sbus ();

  flow_match_table #(.DEPTH(16), .ACTION_W(8), .CNT_W(32), .DEFAULT_ACTION(DEF_ACT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  flow_match_table #(.DEPTH(4), .ACTION_W(4), .CNT_W(4), .DEFAULT_ACTION(4'h5))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

  typedef struct {
    int         due;
    logic       hit;
    logic [3:0] idx;
    logic [7:0] act;
  } res_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // reference model state
  logic         m_vld [DEPTH];
  logic [127:0] m_key [DEPTH];
  logic [7:0]   m_act [DEPTH];
  logic [31:0]  m_cnt [DEPTH];
  logic [31:0]  m_miss;
  res_t         q[$];

  // expected outputs for the current cycle
  logic        e_valid = 0, e_hit = 0, e_sv = 0;
  logic [3:0]  e_idx = 0;
  logic [7:0]  e_act = 0;
  logic [31:0] e_miss = 0, e_sc = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply the spec rules for the current cycle's inputs, then advance one clock.
  task automatic tick();
    res_t r;
    logic n_valid, n_hit, n_sv;
    logic [3:0] n_idx;
    logic [7:0] n_act;
    logic [31:0] n_sc;
    n_valid = 0; n_hit = e_hit; n_idx = e_idx; n_act = e_act; n_sv = 0; n_sc = e_sc;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_vld[i] = 0; m_key[i] = '0; m_act[i] = '0; m_cnt[i] = '0;
      end
      m_miss = '0;
      q.delete();
      n_hit = 0; n_idx = '0; n_act = '0; n_sc = '0;
    end else begin
      n_sv = bus.stat_rd_en;
      if (bus.stat_rd_en) n_sc = m_cnt[bus.stat_idx];
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        if (r.hit) m_cnt[r.idx] = sat32(m_cnt[r.idx]);
        else       m_miss = sat32(m_miss);
      end
      if (bus.valid_flow_key) begin
        r.due = cyc + 2; r.hit = 0; r.idx = '0; r.act = DEF_ACT;
        for (int i = 0; i < DEPTH; i++)
          if (!r.hit && m_vld[i] && m_key[i][103:0] == bus.flow_key[103:0]) begin
            r.hit = 1; r.idx = 4'(i); r.act = m_act[i];
          end
        q.push_back(r);
      end
      if (bus.cfg_wr_en) begin
        m_vld[bus.cfg_idx] = bus.cfg_entry_valid;
        m_key[bus.cfg_idx] = bus.cfg_key;
        m_act[bus.cfg_idx] = bus.cfg_action;
        m_cnt[bus.cfg_idx] = '0;
      end
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        n_valid = 1; n_hit = q[0].hit; n_idx = q[0].idx; n_act = q[0].act;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    e_valid = n_valid; e_hit = n_hit; e_idx = n_idx; e_act = n_act;
    e_sv = n_sv; e_sc = n_sc; e_miss = m_miss;
  endtask

  task automatic idle();
    bus.valid_flow_key = 0; bus.flow_key = '0;
    bus.cfg_wr_en = 0; bus.cfg_idx = '0; bus.cfg_entry_valid = 0;
    bus.cfg_key = '0; bus.cfg_action = '0;
    bus.stat_rd_en = 0; bus.stat_idx = '0;
  endtask

  task automatic lookup(input logic [127:0] k);
    bus.flow_key = k; bus.valid_flow_key = 1;
    tick();
    bus.valid_flow_key = 0;
  endtask

  task automatic cfg_write(input int idx, input logic v, input logic [127:0] k, input logic [7:0] a);
    bus.cfg_wr_en = 1; bus.cfg_idx = 4'(idx); bus.cfg_entry_valid = v;
    bus.cfg_key = k; bus.cfg_action = a;
    tick();
    bus.cfg_wr_en = 0;
  endtask

  task automatic stat_read(input int idx);
    bus.stat_rd_en = 1; bus.stat_idx = 4'(idx);
    tick();
    bus.stat_rd_en = 0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("match_valid",   bus.match_valid,   e_valid);
        chk("match_hit",     bus.match_hit,     e_hit);
        chk("match_idx",     bus.match_idx,     e_idx);
        chk("match_action",  bus.match_action,  e_act);
        chk("miss_cnt",      bus.miss_cnt,      e_miss);
        chk("stat_rd_valid", bus.stat_rd_valid, e_sv);
        chk("stat_hit_cnt",  bus.stat_hit_cnt,  e_sc);
      end
    end
  end

  logic [127:0] k1, k2, k3, kp[4];
  int n;

  initial begin
    k1 = {24'h0, 32'hC0A8_0001, 32'hC0A8_0002, 16'd1234, 16'd80, 8'd6};
    k2 = {24'h0, 32'h0A00_0001, 32'h0A00_0002, 16'd5000, 16'd443, 8'd17};
    k3 = {24'hFFFFFF, k1[103:0]};
    for (int i = 0; i < 4; i++) kp[i] = {$urandom, $urandom, $urandom, $urandom};
    idle();
    sbus.valid_flow_key = 0; sbus.flow_key = '0; sbus.cfg_wr_en = 0; sbus.cfg_idx = '0;
    sbus.cfg_entry_valid = 0; sbus.cfg_key = '0; sbus.cfg_action = '0;
    sbus.stat_rd_en = 0; sbus.stat_idx = '0;

    // reset
    rst_n = 0;
    tick();
    chk_on = 1;
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_match_valid", bus.match_valid, 0);
    chk("rst_miss_cnt", bus.miss_cnt, 0);
    chk("rst_stat_rd_valid", bus.stat_rd_valid, 0);

    // miss on empty table
    lookup(k1); tick();
    chk("miss_valid", bus.match_valid, 1);
    chk("miss_hit", bus.match_hit, 0);
    chk("miss_action", bus.match_action, DEF_ACT);
    tick();
    chk("miss_cnt_1", bus.miss_cnt, 1);

    // install at idx 5 and hit
    cfg_write(5, 1, k1, 8'h3A);
    lookup(k1); tick();
    chk("hit_valid", bus.match_valid, 1);
    chk("hit_idx", bus.match_idx, 5);
    chk("hit_action", bus.match_action, 8'h3A);
    tick();
    stat_read(5);
    chk("stat5_valid", bus.stat_rd_valid, 1);
    chk("stat5_cnt", bus.stat_hit_cnt, 1);

    // duplicate key at 2 and 9, four back-to-back strobes
    cfg_write(2, 1, k2, 8'h22);
    cfg_write(9, 1, k2, 8'h99);
    n = 0;
    bus.flow_key = k2; bus.valid_flow_key = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) bus.valid_flow_key = 0;
      if (bus.match_valid && bus.match_hit && bus.match_idx == 4'd2 && bus.match_action == 8'h22) n++;
    end
    chk("b2b_pulses_idx2", n, 4);
    stat_read(2);
    chk("stat2_cnt", bus.stat_hit_cnt, 4);
    stat_read(9);
    chk("stat9_cnt", bus.stat_hit_cnt, 0);

    // padding bits ignored
    lookup(k3); tick();
    chk("pad_hit", bus.match_hit, 1);
    chk("pad_idx", bus.match_idx, 5);

    // invalidate in the same cycle as a lookup, then lookup again
    bus.cfg_wr_en = 1; bus.cfg_idx = 4'd5; bus.cfg_entry_valid = 0;
    bus.cfg_key = k1; bus.cfg_action = 8'h00;
    lookup(k1);
    bus.cfg_wr_en = 0;
    lookup(k1);
    chk("inval_same_cycle_hit", bus.match_hit, 1);
    chk("inval_same_cycle_idx", bus.match_idx, 5);
    tick();
    chk("inval_next_valid", bus.match_valid, 1);
    chk("inval_next_hit", bus.match_hit, 0);
    chk("inval_next_action", bus.match_action, DEF_ACT);
    tick();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      bus.valid_flow_key = 1'($urandom_range(0, 1));
      bus.flow_key = kp[$urandom_range(0, 3)];
      bus.flow_key[127:104] = 24'($urandom);
      if ($urandom_range(0, 5) == 0) bus.flow_key = {$urandom, $urandom, $urandom, $urandom};
      bus.cfg_wr_en = ($urandom_range(0, 7) == 0);
      bus.cfg_idx = 4'($urandom_range(0, 15));
      bus.cfg_entry_valid = ($urandom_range(0, 3) != 0);
      bus.cfg_key = kp[$urandom_range(0, 3)];
      bus.cfg_action = 8'($urandom);
      bus.stat_rd_en = ($urandom_range(0, 2) == 0);
      bus.stat_idx = 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick(); tick(); tick();

    // narrow counters saturate
    sbus.cfg_wr_en = 1; sbus.cfg_idx = 2'd1; sbus.cfg_entry_valid = 1;
    sbus.cfg_key = k2; sbus.cfg_action = 4'h7;
    tick();
    sbus.cfg_wr_en = 0;
    sbus.flow_key = k2; sbus.valid_flow_key = 1;
    for (int i = 0; i < 20; i++) tick();
    sbus.flow_key = k1;
    for (int i = 0; i < 20; i++) tick();
    sbus.valid_flow_key = 0;
    tick(); tick(); tick();
    sbus.stat_rd_en = 1; sbus.stat_idx = 2'd1;
    tick();
    sbus.stat_rd_en = 0;
    chk("sat_hit_cnt", sbus.stat_hit_cnt, 4'hF);
    chk("sat_miss_cnt", sbus.miss_cnt, 4'hF);

    // reset with two lookups in flight
    bus.flow_key = k2; bus.valid_flow_key = 1;
    tick();
    rst_n = 0;
    tick();
    bus.valid_flow_key = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_valid", bus.match_valid, 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      stat_read(i);
      chk("post_rst_hit_cnt", bus.stat_hit_cnt, 0);
    end
    chk("post_rst_miss_cnt", bus.miss_cnt, 0);
    sbus.stat_rd_en = 1; sbus.stat_idx = 2'd1;
    tick();
    sbus.stat_rd_en = 0;
    chk("post_rst_small_hit_cnt", sbus.stat_hit_cnt, 0);
    chk("post_rst_small_miss_cnt", sbus.miss_cnt, 0);
    tick();

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
